// File: rtl/reg_stream_reader_pkg.sv
// Shared definitions for the vector register read streamer: geometry defaults,
// register select codes (common with the register file) and FSM state encoding.
package rsr_pkg;

  localparam int RSR_DATA_W  = 512;
  localparam int RSR_LANE_W  = 32;
  localparam int RSR_N_LANES = RSR_DATA_W / RSR_LANE_W;
  localparam int RSR_SEL_W   = 2;
  localparam int RSR_IDX_W   = $clog2(RSR_N_LANES);

  localparam logic [1:0] SEL_A1 = 2'b00;
  localparam logic [1:0] SEL_A2 = 2'b01;
  localparam logic [1:0] SEL_A3 = 2'b10;
  localparam logic [1:0] SEL_A4 = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    LOAD   = S_LOAD,
    STREAM = S_STREAM
  } rsr_state_e;

endpackage

// File: rtl/reg_stream_reader_if.sv
// Lane stream carrying one 32-bit slice of a vector register per handshake.
interface reg_stream_reader_if
  import rsr_pkg::*;
#(
  parameter int LANE_W = RSR_LANE_W,
  parameter int SEL_W  = RSR_SEL_W,
  parameter int IDX_W  = RSR_IDX_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [SEL_W-1:0]  out_reg;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_idx, out_reg, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_reg, out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_stream_reader_lane_shift.sv
// Shadow copy of one vector register plus the lane index that walks it, lane 0 first.
module reg_lane_shift #(
  parameter  int DATA_W  = 512,
  parameter  int LANE_W  = 32,
  localparam int N_LANES = DATA_W / LANE_W,
  localparam int IDX_W   = $clog2(N_LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] din,
  output logic [IDX_W-1:0]  idx,
  output logic [LANE_W-1:0] lane
);

  logic [N_LANES-1:0][LANE_W-1:0] shadow;

  // Capture stage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (load) shadow <= din;
  end

  always_ff @(posedge clk) begin
    if (reset)        idx <= '0;
    else if (load)    idx <= '0;
    else if (advance) idx <= idx + IDX_W'(1);
  end

  assign lane = shadow[idx];

endmodule

// File: rtl/reg_stream_reader.sv
// Reads one vector register (or, with RSR_SWEEP_EN defined, sweeps A1..A4) and
// streams it out as 32-bit lanes over a valid/ready handshake.
module reg_stream_reader
  import rsr_pkg::*;
#(
  parameter  int DATA_W  = RSR_DATA_W,
  parameter  int LANE_W  = RSR_LANE_W,
  parameter  int SEL_W   = RSR_SEL_W,
  localparam int N_LANES = DATA_W / LANE_W,
  localparam int IDX_W   = $clog2(N_LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  start_sel,
`ifdef RSR_SWEEP_EN
  input  logic              start_all,
`endif
  output logic [SEL_W-1:0]  regselect,
  input  logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic              done,
  reg_stream_reader_if.master strm
);

  rsr_state_e        state;
  logic              hs;
  logic              last_lane;
  logic              sweeping;
  logic              go_all;
  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;

  assign hs        = strm.out_valid && strm.out_ready;
  assign last_lane = (idx == IDX_W'(N_LANES - 1));

`ifdef RSR_SWEEP_EN
  assign go_all = start_all;

  always_ff @(posedge clk) begin
    if (reset)                                     sweeping <= 1'b0;
    else if (state == IDLE && (start_all || start)) sweeping <= start_all;
  end
`else
  assign go_all   = 1'b0;
  assign sweeping = 1'b0;
`endif

  // Control: start acceptance, one-cycle LOAD, lane streaming, sweep chaining
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      regselect <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go_all) begin
            regselect <= SEL_W'(SEL_A1);
            state     <= LOAD;
          end else if (start) begin
            regselect <= start_sel;
            state     <= LOAD;
          end
        end
        LOAD:   state <= STREAM;
        STREAM: begin
          if (hs && last_lane) begin
            if (sweeping && regselect != SEL_W'(SEL_A4)) begin
              regselect <= regselect + SEL_W'(1);
              state     <= LOAD;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reg_lane_shift #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (state == LOAD),
    .advance (hs),
    .din     (rf_data),
    .idx     (idx),
    .lane    (lane)
  );

  // Output stage: lane fields are forced to zero outside STREAM
  assign busy          = (state != IDLE);
  assign strm.out_valid = (state == STREAM);
  assign strm.out_data  = strm.out_valid ? lane : '0;
  assign strm.out_idx   = idx;
  assign strm.out_reg   = regselect;
  assign strm.out_last  = strm.out_valid && last_lane &&
                          (!sweeping || regselect == SEL_W'(SEL_A4));

endmodule

// File: tb/tb_reg_stream_reader.sv
// Directed/randomized bench for reg_stream_reader; sweep steps run when RSR_SWEEP_EN is defined.
module tb_reg_stream_reader;
  import rsr_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic [1:0]  rg;
    logic        last;
  } lane_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   start_sel = 2'd0;
`ifdef RSR_SWEEP_EN
  logic         start_all = 1'b0;
`endif
  logic [1:0]   regselect;
  logic [511:0] rf_data;
  logic         busy, done;

  logic [511:0] rf [4];
  logic         wr_en = 1'b0;
  logic [1:0]   wr_sel = 2'd0;
  logic [511:0] wr_val = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  reg_stream_reader_if sif ();

  reg_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_sel (start_sel),
`ifdef RSR_SWEEP_EN
    .start_all (start_all),
`endif
    .regselect (regselect),
    .rf_data   (rf_data),
    .busy      (busy),
    .done      (done),
    .strm      (sif)
  );

  always #5 clk = ~clk;

  // Register file model: writes land on the falling edge, reads are combinational
  always @(negedge clk) if (wr_en) rf[wr_sel] <= wr_val;
  assign rf_data = rf[regselect];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rf_write(input int sel, input logic [511:0] val);
    wr_sel = 2'(sel);
    wr_val = val;
    wr_en  = 1'b1;
    @(negedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // mode: 0 ready high, 1 stall lane 5 for 3 cycles, 2 random ready, 3 ready high + start noise
  task automatic run_transfer(input int sel, input bit all, input int mode,
                              input bit wr_load, input logic [511:0] wv1,
                              input bit wr_stream, input logic [511:0] wv2,
                              input int reset_at);
    lane_t        q[$];
    lane_t        e;
    int           nregs, first, stalls, stallrun, guard, popped, t0;
    bit           gap, rdy;
    logic [511:0] snap;
    nregs = all ? 4 : 1;
    first = all ? 0 : sel;
    for (int r = 0; r < nregs; r++) begin
      snap = (wr_load && r == 0) ? wv1 : rf[first + r];
      for (int k = 0; k < 16; k++) begin
        e.data = snap[k*32 +: 32];
        e.idx  = 4'(k);
        e.rg   = 2'(first + r);
        e.last = (k == 15) && (r == nregs - 1);
        q.push_back(e);
      end
    end

    start     = 1'b1;
    start_sel = 2'(sel);
`ifdef RSR_SWEEP_EN
    start_all = all;
`endif
    t0 = cyc;
    step();
    start = 1'b0;
`ifdef RSR_SWEEP_EN
    start_all = 1'b0;
`endif
    chk("load_busy", busy, 1);
    chk("load_valid", sif.out_valid, 0);
    chk("load_regselect", regselect, first);
    chk("load_done", done, 0);
    if (wr_load) begin
      wr_sel = 2'(first);
      wr_val = wv1;
      wr_en  = 1'b1;
    end
    step();
    wr_en = 1'b0;

    stalls = 0; stallrun = 0; gap = 0; guard = 0; popped = 0;
    while (q.size() > 0 && guard < 400) begin
      guard++;
      wr_en = 1'b0;
      if (gap) begin
        chk("gap_valid", sif.out_valid, 0);
        chk("gap_regselect", regselect, q[0].rg);
        gap = 0;
        sif.out_ready = 1'($urandom_range(0, 1));
        step();
        continue;
      end
      chk("valid", sif.out_valid, 1);
      chk("data", sif.out_data, q[0].data);
      chk("idx", sif.out_idx, q[0].idx);
      chk("reg", sif.out_reg, q[0].rg);
      chk("last", sif.out_last, q[0].last);
      chk("regselect", regselect, q[0].rg);
      chk("busy", busy, 1);
      chk("early_done", done, 0);
      if (reset_at >= 0 && int'(q[0].idx) == reset_at) begin
        reset = 1'b1;
        sif.out_ready = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_regselect", regselect, 0);
        chk("rst_done", done, 0);
        chk("rst_last", sif.out_last, 0);
        step();
        chk("rst_done_late", done, 0);
        chk("rst_busy_late", busy, 0);
        return;
      end
      case (mode)
        1: begin
          rdy = !(q[0].idx == 4'd5 && stallrun < 3);
          if (!rdy) stallrun++;
        end
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stalls++;
      if (mode == 3) begin
        start     = 1'b1;
        start_sel = 2'd1;
      end
      if (wr_stream && popped == 3) begin
        wr_sel = 2'(first);
        wr_val = wv2;
        wr_en  = 1'b1;
      end
      sif.out_ready = rdy;
      if (rdy) begin
        e = q.pop_front();
        popped++;
        if (e.idx == 4'd15 && q.size() > 0) gap = 1;
      end
      step();
    end
    start = 1'b0;
    wr_en = 1'b0;
    chk("stream_timeout", q.size(), 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", sif.out_valid, 0);
    chk("done_cycle", cyc - t0, 1 + nregs * 17 + stalls);
  endtask

  initial begin
    logic [511:0] a3, w1, w2;
    sif.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) a3[k*32 +: 32] = 32'hA300_0000 + k;
    rf_write(0, rand512());
    rf_write(1, rand512());
    rf_write(2, a3);
    rf_write(3, rand512());

    reset = 1'b1;
    step();
    step();
    chk("rv_regselect", regselect, 0);
    chk("rv_busy", busy, 0);
    chk("rv_done", done, 0);
    chk("rv_valid", sif.out_valid, 0);
    chk("rv_data", sif.out_data, 0);
    chk("rv_idx", sif.out_idx, 0);
    chk("rv_reg", sif.out_reg, 0);
    chk("rv_last", sif.out_last, 0);
    reset = 1'b0;
    step();

    // A3 read, then back-to-back transfers starting in the done cycle
    run_transfer(2, 0, 0, 0, '0, 0, '0, -1);
    run_transfer(2, 0, 1, 0, '0, 0, '0, -1);
    run_transfer(2, 0, 3, 0, '0, 0, '0, -1);
    for (int i = 0; i < 4; i++)
      run_transfer(int'($urandom_range(0, 3)), 0, 2, 0, '0, 0, '0, -1);

    run_transfer(2, 0, 0, 0, '0, 0, '0, 8);
    run_transfer(2, 0, 0, 0, '0, 0, '0, -1);

    w1 = rand512();
    w2 = rand512();
    run_transfer(0, 0, 0, 1, w1, 1, w2, -1);
    run_transfer(0, 0, 2, 0, '0, 0, '0, -1);

`ifdef RSR_SWEEP_EN
    run_transfer(0, 1, 0, 0, '0, 0, '0, -1);
    run_transfer(3, 1, 2, 0, '0, 0, '0, -1);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_stream_reader.md
# reg_stream_reader

Read-side streaming engine for the 4 x 512-bit vector register file (A1..A4). On a start command it drives the register file's select lines, captures the selected 512-bit register in one cycle, and emits it as sixteen 32-bit lanes over a valid/ready stream. It sits between the register file and narrow consumers such as the output formatter and serial debug port. The parent muxes its `regselect` onto the register file while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 512, register width
- `LANE_W`, 32, stream lane width; `DATA_W` must be a multiple of `LANE_W`
- `N_LANES`, `DATA_W/LANE_W` = 16, derived, not overridable
- `SEL_W`, 2, register select width (00:A1, 01:A2, 10:A3, 11:A4)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin read of `start_sel`; sampled only in IDLE
- `start_sel` in `SEL_W`: register to read
- `start_all` in 1: sweep A1..A4 (only with `RSR_SWEEP_EN`)
- `regselect` out `SEL_W`: select to register file
- `rf_data` in `DATA_W`: register file read data (combinational from `regselect`)
- `busy` out 1: high from the cycle after an accepted start until the return to IDLE
- `done` out 1: one-cycle pulse after the final lane handshake
- `out_valid` out 1, `out_ready` in 1: stream handshake
- `out_data` out `LANE_W`: current lane
- `out_idx` out 4: lane index, 0..15
- `out_reg` out `SEL_W`: register the current lane came from
- `out_last` out 1: final lane of the transfer

## Operation
- States: IDLE, LOAD, STREAM.
- IDLE: on `start`, latch `start_sel` into `regselect` and go to LOAD.
- LOAD (1 cycle): `regselect` is stable. Capture `rf_data` into a 512-bit shadow register at the end of the cycle, set the lane index to 0, go to STREAM.
- STREAM: `out_valid`=1 and `out_data` = shadow[idx*32 +: 32]. Lane 0 is bits [31:0] and goes first.
  - On `out_valid && out_ready`: if idx==15, transfer ends; otherwise idx increments.
  - Transfer end: go to IDLE with `done`=1 next cycle, or, in sweep mode with `out_reg`!=11, increment `regselect` and go to LOAD.
- `out_last` = (idx==15) and (not sweeping, or `out_reg`==11).
- While `out_valid` is high and `out_ready` is low, `out_data`, `out_idx`, `out_reg` and `out_last` hold stable. `out_valid` never drops without a handshake.
- `start` and `start_all` are ignored outside IDLE. If both are asserted together, `start_all` wins.
- The register file updates on the falling edge. The capture sees a write made in the first half of the LOAD cycle. Later writes do not affect the transfer in progress.

## Timing
- Reset values: `regselect`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_reg`=0, `out_last`=0, state IDLE.
- `reset` in any state returns to IDLE the next cycle. A transfer in flight is abandoned with no `done`.
- Single read with `start` sampled at edge 0 and `out_ready` held high:
  - LOAD in cycle 1.
  - Lanes 0..15 in cycles 2..17.
  - `done`=1 and `busy`=0 in cycle 18.
  - A new `start` in cycle 18 is accepted.
- Latency from `start` to first `out_valid`: 2 cycles. Throughput: 1 lane per cycle.
- Each back-pressure cycle adds exactly one cycle.
- Sweep: 4 x (1 LOAD + 16 lanes) = 68 cycles minimum. `out_valid` is low during each intermediate LOAD cycle.

## Configuration
- `RSR_SWEEP_EN` defined: `start_all` port exists; sweep mode as above.
- `RSR_SWEEP_EN` undefined: `start_all` port absent; only single-register transfers; `out_last` = (idx==15).

## Structure
- Shared package `rsr_pkg` holds:
  - the state enum (IDLE, LOAD, STREAM);
  - `DATA_W`, `LANE_W`, `N_LANES` defaults;
  - select constants `SEL_A1`..`SEL_A4` (00..11), shared with the register file.
- One sub-module, `reg_lane_shift`: the 512-bit shadow capture plus lane select/index counter, with `load`, `advance`, `idx`, `lane` ports.
- The FSM stays in the top module.

## Test plan
- Preload A3 so that lane k = 32'hA300_0000+k. Pulse `start` with `start_sel`=10 and hold `out_ready`=1 -> `regselect`=10 in cycle 1, lanes A3000000..A300000F with idx 0..15 in cycles 2..17, `out_last` only on idx 15, `done` in cycle 18.
- Hold `out_ready` low at lane 5 for 3 cycles -> `out_data`=A3000005 and idx=5 stay stable, `out_valid` stays high, `done` arrives 3 cycles later (cycle 21).
- Assert `start` with sel=01 during STREAM -> ignored: `regselect` and data unchanged, still 16 lanes and one `done`.
- Assert `reset` at lane 8 -> next cycle `out_valid`=0, `busy`=0, `regselect`=0, no `done`. A subsequent `start` streams from lane 0.
- Write A1 via the register file in the LOAD cycle's first half, then again during STREAM -> streamed data equals the first write value.
- `RSR_SWEEP_EN`: pulse `start_all` and `start` together -> 64 lanes, `out_reg` 00,01,10,11 in order, one `out_last` at lane 63, `done` at cycle 69 (68 cycles after the LOAD begins in cycle 1).
